// File: rtl/acc_btn_defs.sv
// ---------------------------------------------------------------------------
// acc_btn_defs
//   Shared definitions for the pushbutton conditioning path:
//   debouncer FSM state encodings, the default qualification length for
//   12 MHz boards, and small helpers used by the debouncer.
// ---------------------------------------------------------------------------
package acc_btn_defs;

    // 10 ms of stable samples at 12 MHz.
    localparam int DEFAULT_STABLE_CYCLES = 120000;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ARM_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_ARM_RELEASE = 2'd3
    } btn_state_t;

    // Debounced level implied by a state: the button stays "pressed" while
    // a release is still being qualified, and "released" while a press is.
    function automatic logic level_of(input btn_state_t st);
        return (st == ST_PRESSED) || (st == ST_ARM_RELEASE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit. The reset value is
//   a parameter so the same cell can condition a reset pin as well as data.
//
//   Ports:
//     clk  in   destination clock
//     rst  in   asynchronous, active-high reset
//     d    in   asynchronous input bit
//     q    out  synchronized bit (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//   Conditions a raw, bouncy pushbutton pin into a clean level plus
//   single-cycle press / release pulses, all in the clk domain. A level
//   change is accepted only after the synchronized input has held the new
//   value for STABLE_CYCLES consecutive samples; any opposite sample while
//   qualifying throws the progress away.
//
//   Parameters:
//     STABLE_CYCLES  samples needed to accept a change (>= 2)
//     ACTIVE_LOW     1: pin reads 0 when pressed, 0: pin reads 1 when pressed
//
//   Ports:
//     clk            system clock
//     rst            asynchronous, active-high reset
//     btn_raw        raw pin, asynchronous to clk
//     btn_level      debounced level, 1 = pressed
//     press_pulse    one cycle high on an accepted press
//     release_pulse  one cycle high on an accepted release
// ---------------------------------------------------------------------------
module button_debouncer
    import acc_btn_defs::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Normalize polarity before synchronizing so everything downstream
    // sees 1 = pressed and the synchronizer resets to "not pressed".
    logic btn_n;
    logic s_btn;

    assign btn_n = btn_raw ^ ACTIVE_LOW;

    sync_2ff #(
        .RST_VAL(1'b0)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_n),
        .q  (s_btn)
    );

    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;

        case (state)
            ST_IDLE: begin
                if (s_btn) state_nxt = ST_ARM_PRESS;
            end

            ST_ARM_PRESS: begin
                if (!s_btn) begin
                    state_nxt = ST_IDLE;          // bounce: start over
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_PRESSED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_PRESSED: begin
                if (!s_btn) state_nxt = ST_ARM_RELEASE;
            end

            ST_ARM_RELEASE: begin
                if (s_btn) begin
                    state_nxt = ST_PRESSED;       // bounce: still held
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself. Pulses key on the ARM->settled
        // transition only, so a rejected release (ARM_RELEASE->PRESSED)
        // never fires press_pulse.
        level_nxt   = level_of(state_nxt);
        press_nxt   = (state == ST_ARM_PRESS)   && (state_nxt == ST_PRESSED);
        release_nxt = (state == ST_ARM_RELEASE) && (state_nxt == ST_IDLE);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//   Directed bench for button_debouncer with STABLE_CYCLES=4, ACTIVE_LOW=1.
//   Inputs change 1 ns after a rising edge; outputs are observed 1 ns after
//   each rising edge. Tick k of a window is the observation after the k-th
//   edge of that window, so a change first sampled at edge E0 shows its
//   qualified result at tick STABLE_CYCLES+3 = 7.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int SC = 4;
    localparam int LAT_TICK = SC + 3;

    logic clk;
    logic rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    button_debouncer #(
        .STABLE_CYCLES(SC),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream click counter, as the real consumer would use it.
    logic [7:0] clicks;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              clicks <= 8'd0;
        else if (press_pulse) clicks <= clicks + 8'd1;
    end

    // Pulse exclusivity watcher.
    logic both_seen;
    initial both_seen = 1'b0;
    always @(negedge clk) if (press_pulse && release_pulse) both_seen = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // Observation window bookkeeping.
    int tick_no, pcount, rcount, pfirst, rfirst, lvl_rise, lvl_fall;
    logic lvl_prev, lvl_hi_seen, lvl_lo_seen;

    task automatic clear_window();
        tick_no     = 0;
        pcount      = 0;
        rcount      = 0;
        pfirst      = -1;
        rfirst      = -1;
        lvl_rise    = -1;
        lvl_fall    = -1;
        lvl_prev    = btn_level;
        lvl_hi_seen = 1'b0;
        lvl_lo_seen = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tick_no++;
            if (press_pulse) begin
                pcount++;
                if (pfirst < 0) pfirst = tick_no;
            end
            if (release_pulse) begin
                rcount++;
                if (rfirst < 0) rfirst = tick_no;
            end
            if (btn_level && !lvl_prev && lvl_rise < 0) lvl_rise = tick_no;
            if (!btn_level && lvl_prev && lvl_fall < 0) lvl_fall = tick_no;
            if (btn_level) lvl_hi_seen = 1'b1;
            else           lvl_lo_seen = 1'b1;
            lvl_prev = btn_level;
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        btn_raw = 1'b1;
        #1;
        n_checks++;
        if (btn_level !== 1'b0) begin
            n_errors++; $display("FAIL reset_level: got %b expected 0", btn_level);
        end
        n_checks++;
        if (press_pulse !== 1'b0) begin
            n_errors++; $display("FAIL reset_press: got %b expected 0", press_pulse);
        end
        n_checks++;
        if (release_pulse !== 1'b0) begin
            n_errors++; $display("FAIL reset_release: got %b expected 0", release_pulse);
        end
        clear_window();
        run(3);
        rst = 1'b0;
        run(5);
        n_checks++;
        if (pcount + rcount !== 0 || lvl_hi_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_quiet: got %0d pulses, level_hi %b expected 0 pulses, 0",
                     pcount + rcount, lvl_hi_seen);
        end
    endtask

    task automatic test_clean_press();
        clear_window();
        btn_raw = 1'b0;
        run(20);
        n_checks++;
        if (pcount !== 1) begin
            n_errors++; $display("FAIL press_count: got %0d expected 1", pcount);
        end
        n_checks++;
        if (pfirst !== LAT_TICK) begin
            n_errors++; $display("FAIL press_latency: got tick %0d expected %0d", pfirst, LAT_TICK);
        end
        n_checks++;
        if (lvl_rise !== LAT_TICK) begin
            n_errors++; $display("FAIL press_level_rise: got tick %0d expected %0d", lvl_rise, LAT_TICK);
        end
        n_checks++;
        if (rcount !== 0) begin
            n_errors++; $display("FAIL press_no_release: got %0d expected 0", rcount);
        end
        n_checks++;
        if (btn_level !== 1'b1) begin
            n_errors++; $display("FAIL press_level_hold: got %b expected 1", btn_level);
        end
    endtask

    task automatic test_release_bounce();
        clear_window();
        btn_raw = 1'b1;
        run(2);
        btn_raw = 1'b0;
        run(10);
        n_checks++;
        if (pcount + rcount !== 0) begin
            n_errors++; $display("FAIL rel_bounce_pulses: got %0d expected 0", pcount + rcount);
        end
        n_checks++;
        if (lvl_lo_seen !== 1'b0) begin
            n_errors++; $display("FAIL rel_bounce_level: got low_seen %b expected 0", lvl_lo_seen);
        end
    endtask

    task automatic test_release();
        clear_window();
        btn_raw = 1'b1;
        run(20);
        n_checks++;
        if (rcount !== 1) begin
            n_errors++; $display("FAIL release_count: got %0d expected 1", rcount);
        end
        n_checks++;
        if (rfirst !== LAT_TICK) begin
            n_errors++; $display("FAIL release_latency: got tick %0d expected %0d", rfirst, LAT_TICK);
        end
        n_checks++;
        if (lvl_fall !== LAT_TICK) begin
            n_errors++; $display("FAIL release_level_fall: got tick %0d expected %0d", lvl_fall, LAT_TICK);
        end
        n_checks++;
        if (pcount !== 0) begin
            n_errors++; $display("FAIL release_no_press: got %0d expected 0", pcount);
        end
    endtask

    task automatic test_bounce_reject();
        clear_window();
        btn_raw = 1'b0; run(3);
        btn_raw = 1'b1; run(1);
        btn_raw = 1'b0; run(3);
        btn_raw = 1'b1; run(12);
        n_checks++;
        if (pcount !== 0) begin
            n_errors++; $display("FAIL bounce_no_press: got %0d expected 0", pcount);
        end
        n_checks++;
        if (lvl_hi_seen !== 1'b0) begin
            n_errors++; $display("FAIL bounce_level: got high_seen %b expected 0", lvl_hi_seen);
        end
    endtask

    task automatic test_bounce_settle();
        clear_window();
        btn_raw = 1'b0; run(2);
        btn_raw = 1'b1; run(1);
        btn_raw = 1'b0; run(2);
        btn_raw = 1'b1; run(1);
        btn_raw = 1'b0; run(10);   // final stable low starts at tick 7
        n_checks++;
        if (pcount !== 1) begin
            n_errors++; $display("FAIL settle_count: got %0d expected 1", pcount);
        end
        n_checks++;
        if (pfirst !== 6 + LAT_TICK) begin
            n_errors++; $display("FAIL settle_latency: got tick %0d expected %0d", pfirst, 6 + LAT_TICK);
        end
    endtask

    task automatic test_reset_midop();
        // Return to IDLE first.
        btn_raw = 1'b1;
        run(12);
        clear_window();
        btn_raw = 1'b0;
        run(5);                    // ARM_PRESS with cnt=2 now
        rst = 1'b1;
        #1;
        n_checks++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            n_errors++;
            $display("FAIL midop_reset_outputs: got %b expected 000",
                     {btn_level, press_pulse, release_pulse});
        end
        run(2);
        rst = 1'b0;
        clear_window();
        run(10);
        n_checks++;
        if (pcount !== 1) begin
            n_errors++; $display("FAIL midop_requal_count: got %0d expected 1", pcount);
        end
        n_checks++;
        if (pfirst !== LAT_TICK) begin
            n_errors++; $display("FAIL midop_requal_latency: got tick %0d expected %0d", pfirst, LAT_TICK);
        end
        // Now PRESSED: reset must drop the level without waiting for a clock.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (btn_level !== 1'b0) begin
            n_errors++; $display("FAIL async_reset_level: got %b expected 0", btn_level);
        end
        run(2);
        btn_raw = 1'b1;
        rst = 1'b0;
        run(4);
    endtask

    task automatic test_counter_integration();
        rst = 1'b1;
        btn_raw = 1'b1;
        run(2);
        rst = 1'b0;
        run(2);
        for (int k = 0; k < 5; k++) begin
            btn_raw = 1'b0; run(10);
            btn_raw = 1'b1; run(10);
        end
        n_checks++;
        if (clicks !== 8'd5) begin
            n_errors++; $display("FAIL click_counter: got %0d expected 5", clicks);
        end
        n_checks++;
        if (both_seen !== 1'b0) begin
            n_errors++; $display("FAIL pulse_exclusive: got both_seen %b expected 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_release();
        test_bounce_reject();
        test_bounce_settle();
        test_reset_midop();
        test_counter_integration();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
